// File: rtl/mult_signed_rr_arbiter_if.sv
// Request/response bundle between DSP clients and the shared signed multiplier arbiter.
// Requester i uses bit i of req_valid/req_ready and lanes [16*i+15:16*i] of req_a/req_b.
interface mult_signed_rr_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]    req_valid;
   logic [16*N_REQ-1:0] req_a;
   logic [16*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]    req_ready;
   logic                rsp_valid;
   logic [ID_W-1:0]     rsp_id;
   logic [31:0]         rsp_product;
   logic [3:0]          inflight;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_id, rsp_product, inflight
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_id, rsp_product, inflight
   );
endinterface

// File: rtl/mult_signed_rr_arbiter.sv
// Round-robin arbiter sharing one signed 16x16 multiplier among N_REQ requesters.
// Accepted operands are registered, multiplied, then carried through LAT-1 product registers.
module mult_signed_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int LAT   = 2
) (
   input logic                   clk,
   input logic                   rst,
   input logic                   en,
   mult_signed_rr_arbiter_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    next_ptr;
   logic               grant_found;
   logic [N_REQ-1:0]   grant;
   logic               accept;
   logic signed [15:0] sel_a;
   logic signed [15:0] sel_b;

   logic               s1_valid;
   logic signed [15:0] s1_a;
   logic signed [15:0] s1_b;
   logic [ID_W-1:0]    s1_id;
   logic [31:0]        product;
   logic               rsp_valid_int;
   logic [3:0]         inflight_cnt;

   // Rotating search starting at ptr; the first valid requester found wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % N_REQ);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (grant_found && en && !rst) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign accept   = |grant;
   assign next_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
   assign bus.req_ready = grant;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_idx == ID_W'(k)) begin
            sel_a = bus.req_a[16*k +: 16];
            sel_b = bus.req_b[16*k +: 16];
         end
      end
   end

   // Stage 1 only loads on an accept, so with LAT=1 the outputs hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            ptr   <= next_ptr;
            s1_a  <= sel_a;
            s1_b  <= sel_b;
            s1_id <= grant_idx;
         end
      end
   end

   assign product = 32'(s1_a) * 32'(s1_b);

   generate
      if (LAT == 1) begin : g_lat1
         assign rsp_valid_int   = s1_valid;
         assign bus.rsp_id      = s1_id;
         assign bus.rsp_product = product;
      end else begin : g_pipe
         logic [LAT-2:0]  p_valid;
         logic [31:0]     p_prod [LAT-1];
         logic [ID_W-1:0] p_id   [LAT-1];

         // Payload registers advance only behind a valid op so the last result stays visible.
         always_ff @(posedge clk) begin
            if (rst) begin
               p_valid <= '0;
               for (int k = 0; k < LAT - 1; k++) begin
                  p_prod[k] <= '0;
                  p_id[k]   <= '0;
               end
            end else begin
               p_valid[0] <= s1_valid;
               if (s1_valid) begin
                  p_prod[0] <= product;
                  p_id[0]   <= s1_id;
               end
               for (int k = 1; k < LAT - 1; k++) begin
                  p_valid[k] <= p_valid[k-1];
                  if (p_valid[k-1]) begin
                     p_prod[k] <= p_prod[k-1];
                     p_id[k]   <= p_id[k-1];
                  end
               end
            end
         end

         assign rsp_valid_int   = p_valid[LAT-2];
         assign bus.rsp_id      = p_id[LAT-2];
         assign bus.rsp_product = p_prod[LAT-2];
      end
   endgenerate

   assign bus.rsp_valid = rsp_valid_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_cnt <= '0;
      end else begin
         case ({accept, rsp_valid_int})
            2'b10:   inflight_cnt <= inflight_cnt + 4'd1;
            2'b01:   inflight_cnt <= inflight_cnt - 4'd1;
            default: inflight_cnt <= inflight_cnt;
         endcase
      end
   end

   assign bus.inflight = inflight_cnt;
endmodule
